// File: rtl/param_seq_detector.sv
// Runtime-programmable serial bit-pattern detector.
// The pattern is 1..MAX_LEN bits, LSB-aligned, and is matched against the most
// recent valid input bits. Detection can overlap or not. The Mealy match y is
// combinational from the current bit. y_reg is the same match delayed by one
// cycle. match_count is a saturating count of matches.
module param_seq_detector #(
   parameter int                 MAX_LEN     = 8,
   parameter int                 CNT_W       = 16,
   parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(8'b0000_0101),
   parameter int                 DEF_LEN     = 3,
   parameter logic               DEF_OVERLAP = 1'b1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           in_valid,
   input  logic                           x,
   input  logic                           cfg_load,
   input  logic [MAX_LEN-1:0]             cfg_pattern,
   input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
   input  logic                           cfg_overlap,
   input  logic                           clr_count,
   output logic                           y,
   output logic                           y_reg,
   output logic [CNT_W-1:0]               match_count
);

   localparam int               LW        = $clog2(MAX_LEN + 1);
   localparam logic [LW-1:0]    MAX_LEN_W = LW'(MAX_LEN);
   localparam logic [LW-1:0]    FILL_MAX  = LW'(MAX_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

   logic [MAX_LEN-1:0] pat_r;
   logic [LW-1:0]      len_r;
   logic               ovl_r;
   logic [MAX_LEN-2:0] hist_r;
   logic [LW-1:0]      fill_r;

   logic [MAX_LEN-1:0] win_s;
   logic               eq_s;
   logic               fill_ok_s;
   logic               match_s;
   logic [LW-1:0]      fill_nxt_s;

   // A zero length becomes 1. A length above MAX_LEN becomes MAX_LEN.
   function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] l);
      logic [LW-1:0] r;
      if (l == {LW{1'b0}}) begin
         r = {{(LW-1){1'b0}}, 1'b1};
      end else if (l > MAX_LEN_W) begin
         r = MAX_LEN_W;
      end else begin
         r = l;
      end
      return r;
   endfunction

   // The match window is the current bit plus the history (newest first).
   // A match needs enough valid history and the low len_r bits equal to the pattern.
   always_comb begin
      win_s = {hist_r, x};
      eq_s  = 1'b1;
      for (int i = 0; i < MAX_LEN; i++) begin
         if (i < int'(len_r)) begin
            if (win_s[i] != pat_r[i]) begin
               eq_s = 1'b0;
            end else begin
               eq_s = eq_s;
            end
         end else begin
            eq_s = eq_s;
         end
      end
      fill_ok_s = ({1'b0, fill_r} + {{LW{1'b0}}, 1'b1}) >= {1'b0, len_r};
      match_s   = in_valid & ~cfg_load & ~reset & fill_ok_s & eq_s;
   end

   // Next history fill. It saturates at MAX_LEN-1.
   // A non-overlapping match restarts it at zero, so the next match needs L fresh bits.
   always_comb begin
      if (match_s && !ovl_r) begin
         fill_nxt_s = {LW{1'b0}};
      end else if (fill_r == FILL_MAX) begin
         fill_nxt_s = fill_r;
      end else begin
         fill_nxt_s = fill_r + {{(LW-1){1'b0}}, 1'b1};
      end
   end

   // Configuration and history registers.
   // A config load wipes the history and drops the bit arriving in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         pat_r  <= DEF_PATTERN;
         len_r  <= LW'(DEF_LEN);
         ovl_r  <= DEF_OVERLAP;
         hist_r <= {(MAX_LEN-1){1'b0}};
         fill_r <= {LW{1'b0}};
      end else if (cfg_load) begin
         pat_r  <= cfg_pattern;
         len_r  <= clamp_len(cfg_len);
         ovl_r  <= cfg_overlap;
         hist_r <= {(MAX_LEN-1){1'b0}};
         fill_r <= {LW{1'b0}};
      end else if (in_valid) begin
         hist_r <= win_s[MAX_LEN-2:0];
         fill_r <= fill_nxt_s;
      end else begin
         hist_r <= hist_r;
         fill_r <= fill_r;
      end
   end

   // Registered copy of the match. The match is already forced low during a config load.
   always_ff @(posedge clk) begin
      if (reset) begin
         y_reg <= 1'b0;
      end else begin
         y_reg <= match_s;
      end
   end

   // Saturating match counter. A clear overrides a match in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         match_count <= {CNT_W{1'b0}};
      end else if (clr_count) begin
         match_count <= {CNT_W{1'b0}};
      end else if (match_s && (match_count != CNT_MAX)) begin
         match_count <= match_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         match_count <= match_count;
      end
   end

   assign y = match_s;

endmodule

// File: tb/tb_param_seq_detector.sv
// Directed testbench for param_seq_detector.
// dut uses the default parameters. dut2 uses CNT_W=2, is driven by the same
// inputs, and is used to check counter saturation.
module tb_param_seq_detector;

   logic       clk;
   logic       reset;
   logic       in_valid;
   logic       x;
   logic       cfg_load;
   logic [7:0] cfg_pattern;
   logic [3:0] cfg_len;
   logic       cfg_overlap;
   logic       clr_count;
   logic       y;
   logic       y_reg;
   logic [15:0] match_count;
   logic       y2;
   logic       y_reg2;
   logic [1:0] match_count2;

   int n_checks;
   int n_errors;

   param_seq_detector dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .x           (x),
      .cfg_load    (cfg_load),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_overlap (cfg_overlap),
      .clr_count   (clr_count),
      .y           (y),
      .y_reg       (y_reg),
      .match_count (match_count)
   );

   param_seq_detector #(.CNT_W(2)) dut2 (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .x           (x),
      .cfg_load    (cfg_load),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_overlap (cfg_overlap),
      .clr_count   (clr_count),
      .y           (y2),
      .y_reg       (y_reg2),
      .match_count (match_count2)
   );

   // Free-running clock with a 10-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Send n valid bits, first bit at bits[n-1].
   // Checks y and y2 in the bit's cycle and y_reg one cycle later.
   task automatic send_seq(input string tag, input logic [15:0] bits,
                           input logic [15:0] exp, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         @(negedge clk);
         in_valid = 1'b1;
         x        = bits[i];
         #1;
         check($sformatf("%s_y%0d", tag, n - i), 32'(y), 32'(exp[i]));
         check($sformatf("%s_y2_%0d", tag, n - i), 32'(y2), 32'(exp[i]));
         @(posedge clk);
         #1;
         check($sformatf("%s_yreg%0d", tag, n - i), 32'(y_reg), 32'(exp[i]));
      end
      @(negedge clk);
      in_valid = 1'b0;
      x        = 1'b0;
   endtask

   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
         x        = 1'b1;
         #1;
         check(tag, 32'(y), 32'd0);
      end
   endtask

   task automatic load_cfg(input string tag, input logic [7:0] pat, input logic [3:0] len,
                           input logic ovl, input logic clr, input logic v, input logic b);
      @(negedge clk);
      cfg_load    = 1'b1;
      cfg_pattern = pat;
      cfg_len     = len;
      cfg_overlap = ovl;
      clr_count   = clr;
      in_valid    = v;
      x           = b;
      #1;
      check({tag, "_y"}, 32'(y), 32'd0);
      @(posedge clk);
      #1;
      check({tag, "_yreg"}, 32'(y_reg), 32'd0);
      @(negedge clk);
      cfg_load  = 1'b0;
      clr_count = 1'b0;
      in_valid  = 1'b0;
      x         = 1'b0;
   endtask

   initial begin
      n_checks    = 0;
      n_errors    = 0;
      reset       = 1'b1;
      in_valid    = 1'b1;
      x           = 1'b1;
      cfg_load    = 1'b0;
      cfg_pattern = 8'h00;
      cfg_len     = 4'd0;
      cfg_overlap = 1'b0;
      clr_count   = 1'b0;

      // Reset state.
      @(negedge clk);
      #1;
      check("rst_y", 32'(y), 32'd0);
      @(posedge clk);
      #1;
      check("rst_yreg", 32'(y_reg), 32'd0);
      check("rst_cnt", 32'(match_count), 32'd0);
      @(negedge clk);
      reset    = 1'b0;
      in_valid = 1'b0;
      x        = 1'b0;

      // Test 1: default overlapping "101".
      send_seq("t1", 16'b10101, 16'b00101, 5);
      check("t1_cnt", 32'(match_count), 32'd2);

      // Test 2: non-overlapping "101".
      load_cfg("t2cfg", 8'b0000_0101, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0);
      check("t2_cnt_clr", 32'(match_count), 32'd0);
      send_seq("t2", 16'b10101, 16'b00100, 5);
      check("t2_cnt", 32'(match_count), 32'd1);

      // Test 3: 8-bit pattern with a 3-cycle valid gap after bit 4.
      load_cfg("t3cfg", 8'b1100_1011, 4'd8, 1'b1, 1'b1, 1'b0, 1'b0);
      send_seq("t3a", 16'b1100, 16'b0000, 4);
      idle("t3_gap", 3);
      send_seq("t3b", 16'b1011, 16'b0001, 4);
      check("t3_cnt", 32'(match_count), 32'd1);

      // Test 4a: len=0 is stored as 1, pattern "1".
      load_cfg("t4acfg", 8'b0000_0001, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      send_seq("t4a", 16'b101, 16'b101, 3);
      check("t4a_cnt", 32'(match_count), 32'd2);

      // Test 4b: len=15 is stored as 8.
      load_cfg("t4bcfg", 8'b1100_1011, 4'd15, 1'b1, 1'b1, 1'b0, 1'b0);
      send_seq("t4b", 16'b1100_1011, 16'b0000_0001, 8);
      check("t4b_cnt", 32'(match_count), 32'd1);

      // Test 4c: a bit sent in the config-load cycle is dropped.
      load_cfg("t4cpre", 8'b0000_0101, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
      send_seq("t4c_a", 16'b10, 16'b00, 2);
      load_cfg("t4c_cfg", 8'b0000_0101, 4'd3, 1'b1, 1'b0, 1'b1, 1'b1);
      send_seq("t4c_b", 16'b0101, 16'b0001, 4);
      check("t4c_cnt", 32'(match_count), 32'd1);

      // Test 5: pattern "1" with 6 ones. dut2 saturates at 3.
      load_cfg("t5cfg", 8'b0000_0001, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0);
      send_seq("t5", 16'b111111, 16'b111111, 6);
      check("t5_cnt", 32'(match_count), 32'd6);
      check("t5_cnt_sat", 32'(match_count2), 32'd3);
      clr_count = 1'b1;
      send_seq("t5clr", 16'b1, 16'b1, 1);
      clr_count = 1'b0;
      check("t5_clr_cnt", 32'(match_count), 32'd0);
      check("t5_clr_cnt2", 32'(match_count2), 32'd0);
      send_seq("t5post", 16'b1, 16'b1, 1);
      check("t5_post_cnt", 32'(match_count), 32'd1);
      check("t5_post_cnt2", 32'(match_count2), 32'd1);

      // Test 6: reset in the middle of a partial sequence.
      load_cfg("t6cfg", 8'b0000_0101, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
      send_seq("t6a", 16'b10, 16'b00, 2);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("t6_rst_cnt", 32'(match_count), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      send_seq("t6b", 16'b1101, 16'b0001, 4);
      check("t6_cnt", 32'(match_count), 32'd1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
